// File: rtl/usb_tx.sv
// usb_tx: USB transmit line encoder, 4 clk per bit.
// SYNC, LSB-first serialiser, bit stuffing, NRZI and EOP.
package usb_tx_pkg;
  typedef enum logic [1:0] {
    D_SE0 = 2'b00,
    D_K   = 2'b01,
    D_J   = 2'b10
  } d_port_t;
endpackage

module usb_tx
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output d_port_t    d,
  output logic       oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t     r_state, w_state;
  logic [1:0] r_ph,    w_ph;
  logic [6:0] r_sr,    w_sr;
  logic [2:0] r_bcnt,  w_bcnt;
  logic [2:0] r_ones,  w_ones;
  logic       r_stuff, w_stuff;
  d_port_t    r_d,     w_d;
  logic       r_oe,    w_oe;

  logic    w_ser;
  logic    w_wrap;
  logic    w_do_stuff;
  logic    w_fin;
  logic    w_emit;
  logic    w_next_bit;
  d_port_t w_tog;

  assign w_ser      = (r_state == S_SYNC) ||
                      (r_state == S_DATA);
  assign w_wrap     = (r_ph == 2'd3);
  assign w_do_stuff = !r_stuff && (r_ones == 3'd6);
  assign w_fin      = w_ser && w_wrap && !w_do_stuff;
  assign w_tog      = (r_d == D_K) ? D_J : D_K;

  assign tx_ready = w_fin && (r_bcnt == 3'd7);
  assign busy     = (r_state != S_IDLE);
  assign d        = r_d;
  assign oe       = r_oe;

  always_comb begin
    w_state    = r_state;
    w_ph       = r_ph + 2'd1;
    w_sr       = r_sr;
    w_bcnt     = r_bcnt;
    w_ones     = r_ones;
    w_stuff    = r_stuff;
    w_d        = r_d;
    w_oe       = r_oe;
    w_emit     = 1'b0;
    w_next_bit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ph    = 2'd0;
        w_sr    = 7'b1000000;
        w_bcnt  = 3'd0;
        w_ones  = 3'd0;
        w_stuff = 1'b0;
        w_d     = D_J;
        w_oe    = 1'b0;
        if (tx_valid) begin
          w_state = S_SYNC;
          w_oe    = 1'b1;
          w_d     = D_K;
        end
      end
      S_SYNC, S_DATA: begin
        if (w_wrap) begin
          if (w_do_stuff) begin
            // sr and bcnt hold; the bit is retired after the stuff
            w_stuff = 1'b1;
            w_ones  = 3'd0;
            w_d     = w_tog;
          end else begin
            w_stuff = 1'b0;
            if (r_bcnt == 3'd7) begin
              if (tx_valid) begin
                w_state    = S_DATA;
                w_sr       = tx_data[7:1];
                w_bcnt     = 3'd0;
                w_emit     = 1'b1;
                w_next_bit = tx_data[0];
              end else begin
                w_state = S_EOP_SE0;
                w_bcnt  = 3'd0;
                w_d     = D_SE0;
              end
            end else begin
              w_sr       = {1'b0, r_sr[6:1]};
              w_bcnt     = r_bcnt + 3'd1;
              w_emit     = 1'b1;
              w_next_bit = r_sr[0];
            end
          end
        end
      end
      S_EOP_SE0: begin
        w_d = D_SE0;
        if (w_wrap) begin
          if (r_bcnt[0]) begin
            w_state = S_EOP_J;
            w_d     = D_J;
          end else begin
            w_bcnt = 3'd1;
          end
        end
      end
      S_EOP_J: begin
        w_d = D_J;
        if (w_wrap) begin
          w_state = S_IDLE;
          w_ph    = 2'd0;
          w_oe    = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    if (w_emit) begin
      if (w_next_bit) begin
        w_ones = r_ones + 3'd1;
      end else begin
        w_ones = 3'd0;
        w_d    = w_tog;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ph    <= 2'd0;
      r_sr    <= 7'd0;
      r_bcnt  <= 3'd0;
      r_ones  <= 3'd0;
      r_stuff <= 1'b0;
      r_d     <= D_J;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ph    <= w_ph;
      r_sr    <= w_sr;
      r_bcnt  <= w_bcnt;
      r_ones  <= w_ones;
      r_stuff <= w_stuff;
      r_d     <= w_d;
      r_oe    <= w_oe;
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: random and directed packets checked cycle by
// cycle against a bit-level line model of the encoder.
module tb_usb_tx;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  d_port_t    d;
  logic       oe;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt[$];
  logic [1:0] exp_d[$];
  bit         exp_r[$];

  usb_tx dut (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .d        (d),
    .oe       (oe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d"}, 32'(d), 32'(D_J));
    chk({tag, "_oe"}, 32'(oe), 0);
    chk({tag, "_rdy"}, 32'(tx_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Line model: SYNC + bytes LSB first, stuff after six
  // ones, NRZI, 4 samples per bit, then SE0 x8 and J x4.
  task automatic build_model();
    bit         bits[$];
    logic [1:0] line;
    int         ones;
    exp_d.delete();
    exp_r.delete();
    for (int i = 0; i < 8; i++) bits.push_back(i == 7);
    foreach (pkt[k]) begin
      for (int i = 0; i < 8; i++) bits.push_back(pkt[k][i]);
    end
    line = D_J;
    ones = 0;
    foreach (bits[i]) begin
      if (bits[i]) begin
        ones++;
      end else begin
        ones = 0;
        line = (line == D_J) ? D_K : D_J;
      end
      repeat (4) begin
        exp_d.push_back(line);
        exp_r.push_back(1'b0);
      end
      if (ones == 6) begin
        ones = 0;
        line = (line == D_J) ? D_K : D_J;
        repeat (4) begin
          exp_d.push_back(line);
          exp_r.push_back(1'b0);
        end
      end
      if (i % 8 == 7) exp_r[exp_r.size()-1] = 1'b1;
    end
    repeat (8) begin
      exp_d.push_back(D_SE0);
      exp_r.push_back(1'b0);
    end
    repeat (4) begin
      exp_d.push_back(D_J);
      exp_r.push_back(1'b0);
    end
  endtask

  // Acts as the host: offers pkt bytes, consumes on ready.
  task automatic send(input string tag);
    int n;
    int idx;
    bit rdy;
    n   = pkt.size();
    idx = 0;
    build_model();
    tx_valid = 1'b1;
    tx_data  = (n > 0) ? pkt[0] : $urandom;
    @(posedge clk);
    #1;
    if (n == 0) tx_valid = 1'b0;
    for (int cyc = 0; cyc <= exp_d.size(); cyc++) begin
      @(negedge clk);
      if (cyc == exp_d.size()) begin
        chk_idle({tag, "_end"});
        break;
      end
      chk({tag, "_d"}, 32'(d), 32'(exp_d[cyc]));
      chk({tag, "_oe"}, 32'(oe), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_rdy"}, 32'(tx_ready), 32'(exp_r[cyc]));
      rdy = tx_ready;
      @(posedge clk);
      #1;
      if (rdy && tx_valid) begin
        idx++;
        tx_valid = (idx < n);
        tx_data  = (idx < n) ? pkt[idx] : 8'h00;
      end
    end
    chk({tag, "_taken"}, 32'(idx), 32'(n));
    tx_valid = 1'b0;
  endtask

  initial begin
    // reset held: outputs stay idle whatever tx_valid does
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_valid = ~tx_valid;
      #1;
      chk_idle("rst");
    end
    @(negedge clk);
    tx_valid = 1'b0;
    reset    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("post_rst");
    end

    pkt = '{8'h00};
    send("b00");
    pkt = '{8'hFF};
    send("bFF");
    pkt = '{8'hA5, 8'h3C, 8'h00};
    send("b2b");
    pkt = '{8'hFC};
    send("bFC");
    pkt = {};
    send("empty");

    // async abort mid-DATA, between clock edges
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (50) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("abort");
    tx_valid = 1'b0;
    @(negedge clk);
    chk_idle("abort_hold");
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle("abort_rel");
    end
    pkt = '{8'h5A};
    send("after_abort");

    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(0, 4);
      pkt = {};
      for (int i = 0; i < len; i++) begin
        pkt.push_back(($urandom_range(0, 2) == 0) ?
                      8'hFF : 8'($urandom));
      end
      send("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
